// File: rtl/fetch_entry_queue_pkg.sv
// Shared fetch-queue types and sizing: the decoded fetch entry record and the
// wrap-flagged circular-buffer pointer.
package fetch_entry_queue_pkg;

    localparam int FETCH_WIDTH   = 4;
    localparam int DECODE_WIDTH  = 4;
    localparam int FETCHQ_DEPTH  = 16;
    localparam int FETCHQ_IDX_W  = $clog2(FETCHQ_DEPTH);

    typedef struct packed {
        logic [31:0] inst;
        logic        has_except;
        logic [3:0]  except;
        logic [4:0]  ftq_idx;
        logic [1:0]  ftqOffset;
    } fetchEntry_t;

    typedef struct packed {
        logic                    wrap;
        logic [FETCHQ_IDX_W-1:0] idx;
    } fetchqPtr_t;

endpackage

// File: rtl/fetch_mask_compactor.sv
// Squeezes the valid slots of a sparse fetch packet into a dense, slot-0-first
// prefix and reports how many there are.
module fetch_mask_compactor
    import fetch_entry_queue_pkg::*;
#(
    parameter int FETCH_WIDTH = fetch_entry_queue_pkg::FETCH_WIDTH,
    localparam int EW    = $bits(fetchEntry_t),
    localparam int CNT_W = $clog2(FETCH_WIDTH) + 1
) (
    input  logic [FETCH_WIDTH-1:0]    mask_i,
    input  logic [FETCH_WIDTH*EW-1:0] entry_i,
    output logic [FETCH_WIDTH*EW-1:0] entry_o,
    output logic [FETCH_WIDTH-1:0]    vld_o,
    output logic [CNT_W-1:0]          cnt_o
);

    logic [CNT_W-1:0] pos;

    // Each valid slot lands at the position equal to the number of valid
    // slots below it, so program order is preserved.
    always_comb begin
        entry_o = '0;
        pos     = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (mask_i[i]) begin
                entry_o[int'(pos)*EW +: EW] = entry_i[i*EW +: EW];
                pos = pos + CNT_W'(1);
            end
        end
    end

    assign cnt_o = pos;

    always_comb begin
        vld_o = '0;
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            vld_o[k] = (pos > CNT_W'(k));
        end
    end

endmodule

// File: rtl/fetch_entry_queue.sv
// Instruction buffer between predecode and decode: compacting enqueue, wide
// in-order dequeue, single-cycle squash flush. DEPTH must equal FETCHQ_DEPTH.
module fetch_entry_queue
    import fetch_entry_queue_pkg::*;
#(
    parameter int DEPTH        = fetch_entry_queue_pkg::FETCHQ_DEPTH,
    parameter int FETCH_WIDTH  = fetch_entry_queue_pkg::FETCH_WIDTH,
    parameter int DECODE_WIDTH = fetch_entry_queue_pkg::DECODE_WIDTH,
    localparam int EW    = $bits(fetchEntry_t),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_squash_vld,
    input  logic                       i_enq_req,
    output logic                       o_enq_rdy,
    input  logic [FETCH_WIDTH-1:0]     i_enq_mask,
    input  logic [FETCH_WIDTH*EW-1:0]  i_enq_entry,
    output logic [DECODE_WIDTH-1:0]    o_deq_vld,
    output logic [DECODE_WIDTH*EW-1:0] o_deq_entry,
    input  logic                       i_deq_rdy,
    output logic [CNT_W-1:0]           o_count
);

    localparam int IDX_W = FETCHQ_IDX_W;
    localparam int PTR_W = IDX_W + 1;
    localparam int PC_W  = $clog2(FETCH_WIDTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] FW_C    = CNT_W'(FETCH_WIDTH);
    localparam logic [CNT_W-1:0] DW_C    = CNT_W'(DECODE_WIDTH);

    fetchqPtr_t              head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]        count_q, count_d, deqN;
    logic [EW-1:0]           mem_q [DEPTH];
    logic [FETCH_WIDTH*EW-1:0] cmpEntry;
    logic [FETCH_WIDTH-1:0]  cmpVld;
    logic [PC_W-1:0]         enqN;
    logic                    enqFire, deqFire;

    fetch_mask_compactor #(.FETCH_WIDTH(FETCH_WIDTH)) u_compactor (
        .mask_i  (i_enq_mask),
        .entry_i (i_enq_entry),
        .entry_o (cmpEntry),
        .vld_o   (cmpVld),
        .cnt_o   (enqN)
    );

    // Readiness looks only at registered occupancy so upstream sees no
    // combinational path through the dequeue side.
    assign o_enq_rdy = rst && !i_squash_vld && ((DEPTH_C - count_q) >= FW_C);
    assign enqFire   = i_enq_req && o_enq_rdy;
    assign deqFire   = rst && i_deq_rdy && !i_squash_vld;
    assign deqN      = (count_q < DW_C) ? count_q : DW_C;
    assign o_count   = count_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (i_squash_vld) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enqFire) tail_d = fetchqPtr_t'(PTR_W'(tail_q) + PTR_W'(enqN));
            if (deqFire) head_d = fetchqPtr_t'(PTR_W'(head_q) + PTR_W'(deqN));
            count_d = count_q + (enqFire ? CNT_W'(enqN) : '0) - (deqFire ? deqN : '0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            if (enqFire && (PC_W'(k) < enqN)) begin
                mem_q[tail_q.idx + IDX_W'(k)] <= cmpEntry[k*EW +: EW];
            end
        end
    end

    always_comb begin
        o_deq_vld   = '0;
        o_deq_entry = '0;
        for (int i = 0; i < DECODE_WIDTH; i++) begin
            o_deq_vld[i]            = rst && !i_squash_vld && (count_q > CNT_W'(i));
            o_deq_entry[i*EW +: EW] = mem_q[head_q.idx + IDX_W'(i)];
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            assert (count_q <= DEPTH_C);
            assert (CNT_W'(PTR_W'(tail_q) - PTR_W'(head_q)) == count_q);
            assert ((o_deq_vld & (o_deq_vld + DECODE_WIDTH'(1))) == '0);
            assert ((cmpVld & (cmpVld + FETCH_WIDTH'(1))) == '0);
        end
    end

endmodule

// File: doc/fetch_entry_queue.md
Name: fetch_entry_queue

Overview:
- Instruction buffer between the fetch/predecode stage and decode.
- Accepts one fetch packet per cycle: up to FETCH_WIDTH instructions with a per-slot valid mask. Compacts the valid slots and stores them in order as fetchEntry_t.
- Presents up to DECODE_WIDTH oldest entries to decode per cycle.
- Flushed in one cycle on a backend squash (squashInfo_t valid from the ROB).

Parameters:
- DEPTH, 16, number of fetchEntry_t slots; power of two, must be >= FETCH_WIDTH.
- FETCH_WIDTH, 4, instruction slots per incoming fetch packet.
- DECODE_WIDTH, 4, entries offered to decode per cycle.

Ports:
- clk  input  1  core clock.
- rst  input  1  asynchronous active-low reset; the queue is in reset while rst==0.
- i_squash_vld  input  1  backend squash; flushes the whole queue.
- i_enq_req  input  1  fetch packet valid.
- o_enq_rdy  output  1  queue can accept a full packet this cycle.
- i_enq_mask  input  FETCH_WIDTH  per-slot valid; may be sparse.
- i_enq_entry  input  FETCH_WIDTH x $bits(fetchEntry_t)  packet slots, slot 0 oldest.
- o_deq_vld  output  DECODE_WIDTH  valid per output slot; always a contiguous prefix.
- o_deq_entry  output  DECODE_WIDTH x $bits(fetchEntry_t)  oldest entries, slot 0 oldest.
- i_deq_rdy  input  1  decode consumes all valid output slots this cycle.
- o_count  output  $clog2(DEPTH)+1  current occupancy (debug/perf).

Behaviour:
- Storage: circular buffer. Head and tail pointers are $clog2(DEPTH) index bits plus a wrap flag. Full and empty are distinguished by the wrap flag. The count register is kept consistent with the pointers.
- Reset (rst==0, asynchronous):
  - head=tail=0, count=0, storage contents don't-care.
  - o_deq_vld=0, o_count=0, o_enq_rdy=0 while in reset.
  - Must take effect immediately, including mid-operation.
- Enqueue:
  - o_enq_rdy = rst && !i_squash_vld && (DEPTH - count) >= FETCH_WIDTH. Combinational from registered count only; no dependence on i_enq_req or i_deq_rdy.
  - An enqueue fires when i_enq_req && o_enq_rdy.
  - enq_n = popcount(i_enq_mask). The k-th set mask bit (ascending slot order) is written to storage[tail+k], modulo DEPTH, with wrap-around.
  - tail advances by enq_n.
  - Mask 0 with req: fire is legal, nothing is written, no state change.
- Dequeue:
  - o_deq_vld[i] = (count > i) && !i_squash_vld.
  - o_deq_entry[i] = storage[head+i] modulo DEPTH. Contents are don't-care where vld=0.
  - When i_deq_rdy && !i_squash_vld: deq_n = min(count, DECODE_WIDTH), and head advances by deq_n.
  - i_deq_rdy with count 0 is a no-op.
- Latency: an entry enqueued in cycle N is visible on o_deq_* at cycle N+1 at the earliest. No same-cycle bypass.
- Simultaneous enqueue and dequeue: count_next = count + enq_n - deq_n. Dequeue frees space only for the next cycle.
- Squash (i_squash_vld=1):
  - Next cycle: head=tail=0, count=0.
  - Any enqueue or dequeue in the squash cycle is ignored (enq_rdy and deq_vld are forced 0).
  - Squash has priority over all other events.
- Entries are passed through unmodified, including has_except, except, ftq_idx and ftqOffset. No interpretation of exceptions.
- Fire on a non-ready enqueue is not possible by construction. Upstream must hold the packet stable while o_enq_rdy=0.
- Assertions (sim only):
  - count <= DEPTH.
  - The pointer difference equals count.
  - o_deq_vld is a prefix mask.

Decomposition:
- Shared package (core_config/core_define):
  - FETCH_WIDTH, DECODE_WIDTH, FETCHQ_DEPTH constants.
  - typedef fetchqPtr_t: a struct holding the wrap flag and index.
  - fetchEntry_t is reused unchanged.
- One sub-module: fetch_mask_compactor (combinational). Inputs: FETCH_WIDTH mask and entries. Outputs: prefix-ordered compacted entries, their valid prefix, and popcount.
- The queue top contains pointers, count, storage, squash/reset handling, and output muxing.

Test Plan:
1. After reset, enq mask 4'b1111 with insts A,B,C,D, i_deq_rdy=0 -> next cycle o_deq_vld=4'b1111 carrying A,B,C,D in slots 0..3, o_count=4.
2. Enq mask 4'b1010 with slots W,X,Y,Z -> next cycle o_deq_vld=4'b0011, slot0=X, slot1=Z, o_count=2; except/ftq fields bit-identical.
3. DEPTH=16, i_deq_rdy=0, four full packets -> o_count=16, o_enq_rdy=0, held fifth packet not written. Then one dequeue cycle -> o_count=12, o_enq_rdy=1 the following cycle, fifth packet enqueues; order preserved.
4. Continuous full enq and deq for 12 packets with a ramp -> pointers wrap past 15→0 at least twice, dequeued sequence equals enqueued sequence, o_count never exceeds 16.
5. With 6 entries queued, assert i_squash_vld together with i_enq_req and i_deq_rdy -> o_deq_vld=0 and o_enq_rdy=0 that cycle. Next cycle o_count=0, o_deq_vld=0, and the enqueued packet is dropped.
6. With 7 entries queued, drive rst=0 asynchronously between clock edges -> o_deq_vld, o_count and o_enq_rdy go 0 without waiting for clk. After release, the queue is empty and the first enqueue appears in slot 0.
